traffic_intersection_ctrl: RTL
==============================

// Module: traffic_intersection_ctrl
// PURPOSE
//  Sequences a two-road intersection (main, side) built from per-road light decoders.
//  Main road rests in green; side-road sensor or pedestrian request triggers a full cycle
//  with yellow and all-red clearance. Time advances on a slow `tick` strobe from a prescaler.
//  Moore FSM; outputs drive the light heads directly.
// PARAMETERS
//  CNT_W      8   timer width (bits); every T_* must be >=1 and <= 2**CNT_W-1
//  T_MAIN_MIN 20  minimum main-green duration, ticks
//  T_SIDE     10  side-green duration, ticks
//  T_YELLOW   3   yellow duration (both roads), ticks
//  T_ALLRED   2   all-red clearance duration, ticks
//  T_WALK     8   pedestrian walk duration, ticks (used only with PED_CROSSING_EN)
// PORTS
//  clk         in   1  single clock, all logic on posedge
//  rst_n       in   1  synchronous reset, active-low
//  tick        in   1  1-cycle time strobe; timer advances only when high
//  side_car    in   1  side-road vehicle sensor, level, sampled not latched
//  ped_req     in   1  pedestrian button pulse (ignored without PED_CROSSING_EN)
//  main_red/main_yellow/main_green  out 1 each  main-road lamps
//  side_red/side_yellow/side_green  out 1 each  side-road lamps
//  walk        out  1  pedestrian walk lamp
//  phase       out  3  current state encoding (debug/status)
// BEHAVIOUR
//  States/phase: MG=0 MY=1 AR1=2 SG=3 SY=4 AR2=5 PW=6. 7 unreachable -> AR2 next cycle.
//  Reset (rst_n=0 at edge): state=AR2, timer=0, ped_pend=0; main_red=side_red=1,
//   all other lamps and walk=0, phase=5. Reset mid-operation is identical; no partial state kept.
//  Timer: cleared to 0 on every state change; on tick, increments until T-1 of current state.
//   "done" = tick && timer==T-1, so a state lasts exactly T ticks (T cycles if tick tied 1).
//  Transitions (evaluated at each edge):
//   MG  -> MY  when done-or-saturated (timer==T_MAIN_MIN-1) && tick && (side_car || ped_pend);
//              else stay in MG; timer saturates at T_MAIN_MIN-1
//   MY  -> AR1 on done(T_YELLOW)
//   AR1 -> PW if ped_pend else SG, on done(T_ALLRED)
//   PW  -> SG if side_car else MG, on done(T_WALK)
//   SG  -> SY on done(T_SIDE); SY -> AR2 on done(T_YELLOW); AR2 -> MG on done(T_ALLRED)
//  Moore lamp decode from state register only: exactly one lamp per road is lit.
//   MG: main_green; MY: main_yellow; SG: side_green; SY: side_yellow; other road red.
//   AR1/AR2/PW: both red; walk=1 only in PW.
//  ped_pend: set on ped_req=1 (any state except PW entry cycle); cleared on the edge
//   entering PW; ped_req coinciding with that edge re-sets it (set wins).
//  tick=0 freezes timer and state (except MG->MY needs tick too). side_car dropping before
//   MG minimum expires cancels the request; no memory of it.
// CONFIGURATION
//  `define PED_CROSSING_EN: ped_pend register, PW state and walk lamp implemented as above.
//  Without it: ped_req ignored, ped_pend constant 0, PW never entered, walk tied 0,
//   AR1 always -> SG, MG leaves only on side_car.
// TESTING (tick tied 1, default params, cycle 0 = first edge with rst_n=1)
//  Reset release, side_car=0 -> AR2 cycles 0-1, MG from cycle 2, stays MG for 200 cycles.
//  side_car=1 from cycle 5 -> MG 2-21, MY 22-24, AR1 25-26, SG 27-36, SY 37-39, AR2 40-41, MG 42.
//  side_car pulsed cycles 5-10 only -> MG held, no yellow ever; timer saturated at 19.
//  PED_CROSSING_EN, ped_req pulse cycle 3, side_car=0 -> MY 22, AR1 25, PW 27-34 walk=1, MG 35.
//  tick every 4th cycle -> every phase duration scales x4; rst_n=0 during SG -> next edge all-red AR2.
//  Without macro, ped_req pulses only -> never leaves MG, walk stays 0.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer (main rests green, side/pedestrian requests run a full cycle).
// Optional pedestrian walk phase enabled by `define PED_CROSSING_EN.
module traffic_intersection_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned T_MAIN_MIN = 20,
    parameter int unsigned T_SIDE     = 10,
    parameter int unsigned T_YELLOW   = 3,
    parameter int unsigned T_ALLRED   = 2,
    parameter int unsigned T_WALK     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       side_car,
    input  logic       ped_req,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int unsigned LAMP_W = 7;

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5,
        PW  = 3'd6
    } state_e;

    // Lamp vector order: main r/y/g, side r/y/g, walk
    localparam logic [LAMP_W-1:0] LAMPS_ALLRED = 7'b100_100_0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   limit_c;
    logic               done_c;
    logic [LAMP_W-1:0]  lamps_q, lamps_d;
    logic               ped_pend_q;

    // Per-state terminal count (duration minus one)
    always_comb begin
        limit_c = CNT_W'(T_ALLRED - 1);
        case (state_q)
            MG:      limit_c = CNT_W'(T_MAIN_MIN - 1);
            MY:      limit_c = CNT_W'(T_YELLOW - 1);
            AR1:     limit_c = CNT_W'(T_ALLRED - 1);
            SG:      limit_c = CNT_W'(T_SIDE - 1);
            SY:      limit_c = CNT_W'(T_YELLOW - 1);
            AR2:     limit_c = CNT_W'(T_ALLRED - 1);
            PW:      limit_c = CNT_W'(T_WALK - 1);
            default: limit_c = CNT_W'(T_ALLRED - 1);
        endcase
    end

    assign done_c = tick && (timer_q == limit_c);

    // Next-state, timer and lamp decode
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lamps_d = LAMPS_ALLRED;

        case (state_q)
            MG:  if (done_c && (side_car || ped_pend_q)) state_d = MY;
            MY:  if (done_c) state_d = AR1;
            AR1: if (done_c) state_d = ped_pend_q ? PW : SG;
`ifdef PED_CROSSING_EN
            PW:  if (done_c) state_d = side_car ? SG : MG;
`endif
            SG:  if (done_c) state_d = SY;
            SY:  if (done_c) state_d = AR2;
            AR2: if (done_c) state_d = MG;
            default: state_d = AR2;
        endcase

        // Timer restarts on every state change and saturates at the terminal count
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && (timer_q != limit_c)) begin
            timer_d = timer_q + CNT_W'(1);
        end

        case (state_d)
            MG:      lamps_d = 7'b001_100_0;
            MY:      lamps_d = 7'b010_100_0;
            SG:      lamps_d = 7'b100_001_0;
            SY:      lamps_d = 7'b100_010_0;
            PW:      lamps_d = 7'b100_100_1;
            default: lamps_d = LAMPS_ALLRED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= AR2;
            timer_q <= '0;
            lamps_q <= LAMPS_ALLRED;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lamps_q <= lamps_d;
        end
    end

`ifdef PED_CROSSING_EN
    logic ped_pend_d;

    // Request is consumed on PW entry; a request on that same edge re-arms it
    always_comb begin
        ped_pend_d = ped_pend_q;
        if ((state_d == PW) && (state_q != PW)) begin
            ped_pend_d = ped_req;
        end else if (ped_req) begin
            ped_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end
`else
    logic ped_req_unused;

    assign ped_pend_q     = 1'b0;
    assign ped_req_unused = ped_req;
`endif

    assign {main_red, main_yellow, main_green} = lamps_q[6:4];
    assign {side_red, side_yellow, side_green} = lamps_q[3:1];
    assign walk                                = lamps_q[0];
    assign phase                               = state_q;

endmodule
